asym_fifo: RTL and testbench

Single-clock width-converting FIFO for the PairHMM datapath. It accepts WIDTHA-bit wide words and emits them as RATIO = WIDTHA/WIDTHB narrow WIDTHB-bit words on a valid/ready stream. It is the parametrised successor of the wide-write/narrow-read RAM: it adds occupancy tracking, full/empty/overflow flags, a selectable slice order, synchronous flush, and a prefetch stage for bubble-free output. It sits between the wide host-side loader and the narrow per-PE input streams.

---
 rtl/asym_fifo.sv | 158 +++++++++++++++
 tb/tb_asym_fifo.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_fifo.sv
// rtl/asym_fifo.sv - single-clock wide-write / narrow-read FIFO with prefetch stage
`timescale 1ns/1ps
module asym_fifo #(
   parameter int WIDTHA     = 384,
   parameter int WIDTHB     = 48,
   parameter int DEPTHA     = 128,
   parameter int ADDRWIDTHA = 7,
   parameter int MSB_FIRST  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [WIDTHA-1:0]     wr_data,
   output logic                  full,
   output logic                  overflow,
   output logic [ADDRWIDTHA:0]   level,
   output logic                  empty,
   output logic [WIDTHB-1:0]     dout,
   output logic                  dout_valid,
   input  logic                  dout_ready
);

   localparam int RATIO = WIDTHA / WIDTHB;
   localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   localparam logic [SW-1:0]         LAST_IDX   = SW'(RATIO - 1);
   localparam logic [SW-1:0]         IDX_ONE    = SW'(1);
   localparam logic [ADDRWIDTHA-1:0] PTR_ONE    = ADDRWIDTHA'(1);
   localparam logic [ADDRWIDTHA:0]   LVL_ONE    = (ADDRWIDTHA + 1)'(1);
   localparam logic [ADDRWIDTHA:0]   FULL_LEVEL = (ADDRWIDTHA + 1)'(DEPTHA);

   // wide-entry storage
   logic [WIDTHA-1:0]     r_mem [DEPTHA];

   logic [ADDRWIDTHA-1:0] r_wr_ptr;
   logic [ADDRWIDTHA-1:0] r_rd_ptr;
   logic [ADDRWIDTHA:0]   r_level;
   logic                  r_overflow;

   // prefetch stage between RAM and holding register
   logic                  r_s1_valid;
   logic [WIDTHA-1:0]     r_s1_data;

   // holding register being sliced onto dout
   logic                  r_hold_valid;
   logic [WIDTHA-1:0]     r_hold;
   logic [SW-1:0]         r_idx;

   logic                  w_wr_accept;
   logic                  w_consume;
   logic                  w_last_consume;
   logic                  w_hold_load;
   logic                  w_rd_issue;
   logic [SW-1:0]         w_sel;

   assign full           = (r_level == FULL_LEVEL);
   assign empty          = (r_level == '0) && !r_s1_valid && !r_hold_valid;
   assign level          = r_level;
   assign overflow       = r_overflow;
   assign dout_valid     = r_hold_valid;

   // a write in the flush cycle is dropped outright
   assign w_wr_accept    = wr_en && !full && !flush;
   assign w_consume      = r_hold_valid && dout_ready;
   assign w_last_consume = w_consume && (r_idx == LAST_IDX);
   // stage1 hands over when hold is free or finishing its last slice
   assign w_hold_load    = r_s1_valid && (!r_hold_valid || w_last_consume);
   // refill stage1 in the same cycle it empties so entries stream without bubbles
   assign w_rd_issue     = (r_level != '0) && (!r_s1_valid || w_hold_load);
   assign w_sel          = (MSB_FIRST != 0) ? (LAST_IDX - r_idx) : r_idx;

   // RAM write port; never collides with the read because the read needs level>0
   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_wr_accept && !w_rd_issue) begin
            r_level <= r_level + LVL_ONE;
         end else if (!w_wr_accept && w_rd_issue) begin
            r_level <= r_level - LVL_ONE;
         end
         if (wr_en && full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // prefetch stage: loads on rd_issue, empties when hold takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else if (flush) begin
         r_s1_valid <= 1'b0;
      end else if (w_rd_issue) begin
         r_s1_valid <= 1'b1;
         r_s1_data  <= r_mem[r_rd_ptr];
      end else if (w_hold_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   // holding register and slice index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_idx        <= '0;
      end else if (flush) begin
         r_hold_valid <= 1'b0;
         r_idx        <= '0;
      end else if (w_hold_load) begin
         r_hold       <= r_s1_data;
         r_hold_valid <= 1'b1;
         r_idx        <= '0;
      end else if (w_consume) begin
         if (r_idx == LAST_IDX) begin
            r_hold_valid <= 1'b0;
            r_idx        <= '0;
         end else begin
            r_idx <= r_idx + IDX_ONE;
         end
      end
   end

   // slice selection onto the narrow output
   always_comb begin
      dout = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (w_sel == SW'(k)) begin
            dout = r_hold[k*WIDTHB +: WIDTHB];
         end
      end
   end

endmodule

// File: tb/tb_asym_fifo.sv
// tb/tb_asym_fifo.sv - self-checking bench for asym_fifo
`timescale 1ns/1ps
module tb_asym_fifo;

   localparam int WA    = 384;
   localparam int WB    = 48;
   localparam int DA    = 128;
   localparam int AW    = 7;
   localparam int RATIO = WA / WB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic [WA-1:0] wr_data = '0;
   logic          dout_ready = 1'b0;

   logic          full, overflow, empty, dout_valid;
   logic [AW:0]   level;
   logic [WB-1:0] dout;

   logic          full_m, overflow_m, empty_m, dout_valid_m;
   logic [AW:0]   level_m;
   logic [WB-1:0] dout_m;

   int n_checks = 0;
   int n_fail   = 0;

   // expected narrow words, oldest first
   logic [WB-1:0] q[$];

   always #5 clk = ~clk;

   asym_fifo #(.WIDTHA(WA), .WIDTHB(WB), .DEPTHA(DA), .ADDRWIDTHA(AW), .MSB_FIRST(0)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .overflow(overflow), .level(level), .empty(empty),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
   );

   asym_fifo #(.WIDTHA(WA), .WIDTHB(WB), .DEPTHA(DA), .ADDRWIDTHA(AW), .MSB_FIRST(1)) dut_m (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .full(full_m), .overflow(overflow_m), .level(level_m), .empty(empty_m),
      .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready)
   );

   function automatic logic [WA-1:0] rand_word();
      logic [WA-1:0] w;
      for (int k = 0; k < WA / 32; k++) w[k*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [WA-1:0] pattern_word();
      logic [WA-1:0] w;
      for (int k = 0; k < RATIO; k++) w[k*WB +: WB] = WB'(k * 16);
      return w;
   endfunction

   task automatic push_word(input logic [WA-1:0] w);
      for (int k = 0; k < RATIO; k++) q.push_back(w[k*WB +: WB]);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dout_valid, full, empty, overflow, level, dout} !== {4'b0010, 8'd0, 48'd0}) begin
         n_fail++;
         $display("FAIL reset_state: got v=%0b f=%0b e=%0b o=%0b lvl=%0d dout=%h, want v=0 f=0 e=1 o=0 lvl=0 dout=0",
                  dout_valid, full, empty, overflow, level, dout);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      @(negedge clk);
      dout_ready = 1'b1; wr_en = 1'b1; wr_data = pattern_word();
      @(negedge clk);
      wr_en = 1'b0;
      n_checks++;
      if (level !== 8'd1 || dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_cycle1: got level=%0d valid=%0b, want level=1 valid=0", level, dout_valid);
      end
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b0 || empty !== 1'b0 || level !== 8'd0) begin
         n_fail++; $display("FAIL basic_cycle2: got valid=%0b empty=%0b level=%0d, want 0 0 0", dout_valid, empty, level);
      end
      for (int k = 0; k < RATIO; k++) begin
         @(negedge clk);
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== WB'(k * 16)) begin
            n_fail++; $display("FAIL basic_slice%0d: got valid=%0b dout=%h, want valid=1 dout=%h", k, dout_valid, dout, WB'(k * 16));
         end
      end
      @(negedge clk);
      n_checks++;
      if (empty !== 1'b1 || dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_empty_after: got empty=%0b valid=%0b, want 1 0", empty, dout_valid);
      end
   endtask

   task automatic test_order();
      @(negedge clk);
      dout_ready = 1'b1; wr_en = 1'b1; wr_data = pattern_word();
      @(negedge clk);
      wr_en = 1'b0;
      n_checks++;
      if (level_m !== 8'd1) begin
         n_fail++; $display("FAIL order_level: got %0d, want 1", level_m);
      end
      @(negedge clk);
      for (int k = 0; k < RATIO; k++) begin
         @(negedge clk);
         n_checks++;
         if (dout_valid_m !== 1'b1 || dout_m !== WB'((RATIO - 1 - k) * 16)) begin
            n_fail++; $display("FAIL order_slice%0d: got valid=%0b dout=%h, want valid=1 dout=%h",
                               k, dout_valid_m, dout_m, WB'((RATIO - 1 - k) * 16));
         end
      end
      @(negedge clk);
      n_checks++;
      if (empty_m !== 1'b1) begin
         n_fail++; $display("FAIL order_empty_after: got %0b, want 1", empty_m);
      end
   endtask

   // two entries sit in stage1/hold, so DEPTHA+2 writes are needed before full
   task automatic test_fill();
      q.delete();
      dout_ready = 1'b0;
      for (int i = 0; i < DA + 2; i++) begin
         @(negedge clk);
         if (i == DA + 1) begin
            n_checks++;
            if (level !== 8'(DA - 1) || full !== 1'b0) begin
               n_fail++; $display("FAIL fill_before_last: got level=%0d full=%0b, want level=%0d full=0", level, full, DA - 1);
            end
         end
         wr_en = 1'b1; wr_data = rand_word(); push_word(wr_data);
      end
      @(negedge clk);
      wr_en = 1'b0;
      n_checks++;
      if (full !== 1'b1 || level !== 8'(DA) || overflow !== 1'b0) begin
         n_fail++; $display("FAIL fill_full: got full=%0b level=%0d ovf=%0b, want full=1 level=%0d ovf=0", full, level, overflow, DA);
      end
      wr_en = 1'b1; wr_data = rand_word();
      @(negedge clk);
      wr_en = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || level !== 8'(DA) || full !== 1'b1) begin
         n_fail++; $display("FAIL fill_overflow: got ovf=%0b level=%0d full=%0b, want ovf=1 level=%0d full=1", overflow, level, full, DA);
      end
      n_checks++;
      if ({full_m, overflow_m} !== 2'b11) begin
         n_fail++; $display("FAIL fill_overflow_msb: got full=%0b ovf=%0b, want 1 1", full_m, overflow_m);
      end
   endtask

   task automatic test_drain();
      logic [WB-1:0] exp;
      for (int i = 0; i < (DA + 2) * RATIO; i++) begin
         @(negedge clk);
         dout_ready = 1'b1;
         if (i == RATIO - 1) begin
            n_checks++;
            if (full !== 1'b1) begin n_fail++; $display("FAIL drain_full_held: got %0b, want 1", full); end
         end
         if (i == RATIO) begin
            n_checks++;
            if (full !== 1'b0) begin n_fail++; $display("FAIL drain_full_fall: got %0b, want 0", full); end
         end
         exp = q.pop_front();
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== exp) begin
            n_fail++; $display("FAIL drain_word%0d: got valid=%0b dout=%h, want valid=1 dout=%h", i, dout_valid, dout, exp);
         end
      end
      @(negedge clk);
      n_checks++;
      if (empty !== 1'b1 || dout_valid !== 1'b0) begin
         n_fail++; $display("FAIL drain_empty: got empty=%0b valid=%0b, want 1 0", empty, dout_valid);
      end
   endtask

   task automatic test_flush();
      int wi = 0;
      int consumed = 0;
      int cyc = 0;
      bit done = 1'b0;
      logic [WB-1:0] exp;
      logic [WA-1:0] w;
      q.delete();
      n_checks++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL flush_pre_overflow: got %0b, want 1", overflow); end
      dout_ready = 1'b1;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         wr_en = 1'b0;
         if (dout_valid) begin
            exp = q.pop_front();
            n_checks++;
            if (dout !== exp) begin
               n_fail++; $display("FAIL flush_stream_word%0d: got %h, want %h", consumed, dout, exp);
            end
            consumed++;
            // entry 5 slice 3 is on dout this cycle
            if (consumed == 5 * RATIO + 4) begin
               flush = 1'b1; wr_en = 1'b1; wr_data = rand_word(); done = 1'b1;
            end
         end
         if (!done && wi < 8) begin
            wr_en = 1'b1; wr_data = rand_word(); push_word(wr_data); wi++;
         end
      end
      n_checks++;
      if (!done) begin n_fail++; $display("FAIL flush_timeout: got %0d words, want %0d", consumed, 5 * RATIO + 4); end
      @(negedge clk);
      flush = 1'b0; wr_en = 1'b0; q.delete();
      n_checks++;
      if ({dout_valid, level, empty, overflow} !== {1'b0, 8'd0, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL flush_cleared: got valid=%0b level=%0d empty=%0b ovf=%0b, want 0 0 1 0",
                            dout_valid, level, empty, overflow);
      end
      w = rand_word();
      wr_en = 1'b1; wr_data = w; push_word(w);
      for (int c = 1; c <= 3 + RATIO; c++) begin
         @(negedge clk);
         wr_en = 1'b0;
         if (c < 3) begin
            n_checks++;
            if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL flush_fresh_early%0d: got valid=1, want 0", c); end
         end else if (c < 3 + RATIO) begin
            exp = q.pop_front();
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== exp) begin
               n_fail++; $display("FAIL flush_fresh_slice%0d: got valid=%0b dout=%h, want 1 %h", c - 3, dout_valid, dout, exp);
            end
         end else begin
            n_checks++;
            if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_fresh_empty: got %0b, want 1", empty); end
         end
      end
   endtask

   task automatic test_backpressure();
      int wrote = 0;
      int got = 0;
      int cyc = 0;
      logic prev_stall = 1'b0;
      logic [WB-1:0] prev_dout = '0;
      logic [WB-1:0] exp;
      q.delete();
      while (got < 300 * RATIO && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (prev_stall) begin
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== prev_dout) begin
               n_fail++; $display("FAIL bp_stall_stable: got valid=%0b dout=%h, want valid=1 dout=%h", dout_valid, dout, prev_dout);
            end
         end
         dout_ready = ($urandom % 2) == 0;
         if (dout_valid && dout_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL bp_unexpected_word: got %h, want no output", dout);
            end else begin
               exp = q.pop_front();
               if (dout !== exp) begin
                  n_fail++; $display("FAIL bp_word%0d: got %h, want %h", got, dout, exp);
               end
            end
            got++;
         end
         prev_stall = dout_valid && !dout_ready;
         prev_dout  = dout;
         wr_en = 1'b0;
         if (wrote < 300 && q.size() < 64 * RATIO && ($urandom % 4) != 0) begin
            wr_en = 1'b1; wr_data = rand_word(); push_word(wr_data); wrote++;
         end
      end
      n_checks++;
      if (got < 300 * RATIO) begin n_fail++; $display("FAIL bp_timeout: got %0d words, want %0d", got, 300 * RATIO); end
      @(negedge clk);
      wr_en = 1'b0;
      n_checks++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL bp_empty_end: got %0b, want 1", empty); end
   endtask

   task automatic test_async_reset();
      logic [WA-1:0] w;
      q.delete();
      dout_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_data = rand_word();
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wr_en = 1'b0;
      end
      n_checks++;
      if (dout_valid !== 1'b1 || empty !== 1'b0) begin
         n_fail++; $display("FAIL areset_pre: got valid=%0b empty=%0b, want 1 0", dout_valid, empty);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dout_valid, full, empty, overflow, level, dout} !== {4'b0010, 8'd0, 48'd0}) begin
         n_fail++; $display("FAIL areset_state: got v=%0b f=%0b e=%0b o=%0b lvl=%0d dout=%h, want v=0 f=0 e=1 o=0 lvl=0 dout=0",
                            dout_valid, full, empty, overflow, level, dout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      w = rand_word();
      wr_en = 1'b1; wr_data = w; dout_ready = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== w[WB-1:0]) begin
         n_fail++; $display("FAIL areset_fresh: got valid=%0b dout=%h, want valid=1 dout=%h", dout_valid, dout, w[WB-1:0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_order();
      test_fill();
      test_drain();
      test_flush();
      test_backpressure();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
